systolic_stream_mm: RTL and testbench
=====================================

Name: systolic_stream_mm

Overview:
- Output-stationary SIZE x SIZE systolic matrix-multiply engine computing C = A(SIZE x K) * B(K x SIZE), with K set per job via k_len.
- Successor to the fixed 8x8 single-shot array: generalised in size, depth and signedness, with streamed operands, internal skewing and valid/ready handshakes.
- Sits between the operand buffers and the result writeback path.

Parameters:
- SIZE, 4, array dimension (rows = cols), >= 2.
- DATA_WIDTH, 8, operand width in bits.
- K_MAX, 16, maximum inner dimension per job.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(K_MAX), accumulator and result element width; overflow is impossible by construction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  job request; honoured only in IDLE.
- k_len  in  $clog2(K_MAX+1)  inner dimension K; sampled with start.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- a_valid  in  1  operand beat valid.
- a_ready  out  1  operand beat accepted when a_valid & a_ready.
- a_col  in  SIZE*DATA_WIDTH  column k of A; slice i = A[i][k].
- b_row  in  SIZE*DATA_WIDTH  row k of B; slice j = B[k][j].
- c_valid  out  1  result matrix valid.
- c_ready  in  1  result consumer ready.
- c_data  out  SIZE*SIZE*ACC_WIDTH  slice (i*SIZE+j) = C[i][j].
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on the result handshake.

Behaviour:
- Reset (async, rst=1): FSM = IDLE; all accumulators, skew registers and beat counters = 0; a_ready=0, c_valid=0, busy=0, done=0, c_data=0.
- FSM states: IDLE, LOAD, DRAIN, OUT.
- IDLE -> LOAD on start:
  - latch k_len_eff = min(k_len, K_MAX) and signed_mode;
  - clear all accumulators;
  - clear beat counter.
  - If k_len==0, go IDLE -> OUT directly with c_data = 0.
- LOAD:
  - a_ready=1.
  - Each accepted beat increments the beat counter.
  - After the k_len_eff-th accepted beat: a_ready drops on the next cycle and the FSM moves to DRAIN.
- Array timing:
  - The array advances every cycle regardless of a_valid; cycles without a handshake inject zero operands (bubbles), so results are unaffected.
  - Row i of A is delayed i cycles; column j of B is delayed j cycles.
  - PE(i,j) registers its A operand to the right and its B operand downward.
  - Each PE performs acc += a*b, sign-extended to ACC_WIDTH when signed_mode=1, zero-extended otherwise.
- DRAIN:
  - Lasts exactly 2*SIZE-1 cycles (counter), then -> OUT.
  - c_valid rises on the 2*SIZE-th rising edge after the edge that accepted the final beat.
- OUT:
  - c_valid=1; c_data holds the accumulator snapshot, stable until the handshake.
  - On c_valid & c_ready: done=1 for that cycle, then -> IDLE.
  - c_ready may be low indefinitely; no data is lost.
- start while busy: ignored, with no effect on the current job.
- a_valid outside LOAD: ignored (a_ready=0).
- Reset mid-job: immediate abort; returns to the reset state; no done pulse.
- Back-to-back jobs: start may be asserted in the cycle after done.

Optional Feature:
- SYSTOLIC_PERF_CNT_EN defined:
  - Adds output port cycle_count (16 bits, reset 0).
  - Cleared on an accepted start; increments every cycle while busy; saturates at 16'hFFFF.
  - Holds its value in IDLE.
- Not defined: port and counter absent; all other behaviour is identical.

Test Plan:
- SIZE=4, k_len=4, signed_mode=0, A=identity, B[k][j]=4k+j, one beat per cycle, c_ready=1 -> c_data == B; c_valid 8 cycles after the last beat; done pulses once.
- signed_mode=1, k_len=2, A[i][k]=-128, B[k][j]=-128 -> every C[i][j]=32768; rerun with signed_mode=0 and 0x80 operands -> 32768.
- k_len=5 with a_valid toggling 1,0,0,1,1,0,1,1 and random unsigned data -> matches reference model; a_ready low after the 5th accepted beat.
- c_ready held low for 20 cycles in OUT -> c_valid stays 1, c_data unchanged; done only on the cycle c_ready rises.
- start pulsed during LOAD and DRAIN -> ignored; a start with k_len=0 -> OUT next cycle with all zeros; k_len=20 -> clamped to 16 beats.
- rst asserted mid-LOAD -> all outputs 0 immediately (async); the next job computes correctly from clean accumulators.

Source files
------------

// File: rtl/systolic_stream_mm.sv
// systolic_stream_mm: output-stationary SIZE x SIZE systolic matrix multiply with streamed, internally skewed operands.
// Optional SYSTOLIC_PERF_CNT_EN adds a saturating busy-cycle counter on port cycle_count.
module systolic_stream_mm #(
   parameter int SIZE       = 4,
   parameter int DATA_WIDTH = 8,
   parameter int K_MAX      = 16,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH+$clog2(K_MAX)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [$clog2(K_MAX+1)-1:0]      k_len,
   input  logic                            signed_mode,
   input  logic                            a_valid,
   output logic                            a_ready,
   input  logic [SIZE*DATA_WIDTH-1:0]      a_col,
   input  logic [SIZE*DATA_WIDTH-1:0]      b_row,
   output logic                            c_valid,
   input  logic                            c_ready,
   output logic [SIZE*SIZE*ACC_WIDTH-1:0]  c_data,
   output logic                            busy,
   output logic                            done
`ifdef SYSTOLIC_PERF_CNT_EN
   ,
   output logic [15:0]                     cycle_count
`endif
);
   localparam int DW  = DATA_WIDTH;
   localparam int KW  = $clog2(K_MAX+1);
   localparam int DCW = $clog2(2*SIZE);
   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;
   state_t state, state_n;
   logic [KW-1:0] k_eff, beat;
   logic [DCW-1:0] drain;
   logic sm, go, a_fire, last_beat;
   logic [DW-1:0] a_in [SIZE];
   logic [DW-1:0] b_in [SIZE];
   logic [DW-1:0] a_h [SIZE][SIZE];
   logic [DW-1:0] b_v [SIZE][SIZE];
   logic [DW-1:0] a_q [SIZE][SIZE-1];
   logic [DW-1:0] b_q [SIZE-1][SIZE];
   logic [ACC_WIDTH-1:0] acc [SIZE][SIZE];
   logic [SIZE*SIZE*ACC_WIDTH-1:0] acc_flat;

   // Low ACC_WIDTH bits of the product are identical for signed and unsigned once extended.
   function automatic logic [ACC_WIDTH-1:0] ext(input logic [DW-1:0] v, input logic s);
      return {{(ACC_WIDTH-DW){s & v[DW-1]}}, v};
   endfunction

   assign a_ready   = state == LOAD;
   assign busy      = state != IDLE;
   assign go        = state == IDLE && start;
   assign a_fire    = a_valid && a_ready;
   assign last_beat = a_fire && beat == k_eff - KW'(1);
   assign done      = c_valid && c_ready;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_n;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = k_len == '0 ? OUT : LOAD;
         LOAD:    if (last_beat) state_n = DRAIN;
         DRAIN:   if (drain == DCW'(2*SIZE-2)) state_n = OUT;
         OUT:     if (done) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         k_eff   <= '0;
         beat    <= '0;
         drain   <= '0;
         sm      <= 1'b0;
         c_valid <= 1'b0;
         c_data  <= '0;
      end else begin
         if (go) begin
            k_eff <= k_len > KW'(K_MAX) ? KW'(K_MAX) : k_len;
            sm    <= signed_mode;
            beat  <= '0;
            drain <= '0;
         end
         if (a_fire) beat <= beat + KW'(1);
         if (state == DRAIN) drain <= drain + DCW'(1);
         if (go && k_len == '0) begin
            c_valid <= 1'b1;
            c_data  <= '0;
         end else if (state == OUT && !c_valid) begin
            c_valid <= 1'b1;
            c_data  <= acc_flat;
         end else if (done) c_valid <= 1'b0;
      end

   // Row i of A and column i of B enter the array i cycles late; idle cycles inject zeros.
   for (genvar i = 0; i < SIZE; i++) begin : g_skew
      logic [DW-1:0] a_x, b_x;
      assign a_x = a_fire ? a_col[i*DW +: DW] : '0;
      assign b_x = a_fire ? b_row[i*DW +: DW] : '0;
      if (i == 0) begin : g_d0
         assign a_in[i] = a_x;
         assign b_in[i] = b_x;
      end else begin : g_dn
         logic [DW-1:0] a_sr [i];
         logic [DW-1:0] b_sr [i];
         always_ff @(posedge clk or posedge rst)
            if (rst) begin
               for (int d = 0; d < i; d++) begin
                  a_sr[d] <= '0;
                  b_sr[d] <= '0;
               end
            end else begin
               a_sr[0] <= a_x;
               b_sr[0] <= b_x;
               for (int d = 1; d < i; d++) begin
                  a_sr[d] <= a_sr[d-1];
                  b_sr[d] <= b_sr[d-1];
               end
            end
         assign a_in[i] = a_sr[i-1];
         assign b_in[i] = b_sr[i-1];
      end
   end

   for (genvar i = 0; i < SIZE; i++) begin : g_row
      for (genvar j = 0; j < SIZE; j++) begin : g_col
         if (j == 0) begin : g_al
            assign a_h[i][j] = a_in[i];
         end else begin : g_al
            assign a_h[i][j] = a_q[i][j-1];
         end
         if (i == 0) begin : g_bt
            assign b_v[i][j] = b_in[j];
         end else begin : g_bt
            assign b_v[i][j] = b_q[i-1][j];
         end
         assign acc_flat[(i*SIZE+j)*ACC_WIDTH +: ACC_WIDTH] = acc[i][j];
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) acc[i][j] <= '0;
         for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE-1; j++) a_q[i][j] <= '0;
         for (int i = 0; i < SIZE-1; i++)
            for (int j = 0; j < SIZE; j++) b_q[i][j] <= '0;
      end else begin
         for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
               acc[i][j] <= go ? '0 : acc[i][j] + ext(a_h[i][j], sm) * ext(b_v[i][j], sm);
         for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE-1; j++) a_q[i][j] <= a_h[i][j];
         for (int i = 0; i < SIZE-1; i++)
            for (int j = 0; j < SIZE; j++) b_q[i][j] <= b_v[i][j];
      end

`ifdef SYSTOLIC_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst)
      if (rst)                                   cycle_count <= '0;
      else if (go)                               cycle_count <= '0;
      else if (busy && cycle_count != 16'hFFFF)  cycle_count <= cycle_count + 16'd1;
`endif
endmodule

// File: tb/tb_systolic_stream_mm.sv
// tb_systolic_stream_mm: randomized jobs checked against a plain-arithmetic matrix model every output cycle.
module tb_systolic_stream_mm;
   localparam int S  = 4;
   localparam int DW = 8;
   localparam int KM = 16;
   localparam int AW = 20;
   localparam int KW = 5;
   localparam int CW = S*S*AW;

   logic clk = 0, rst = 1, start = 0, signed_mode = 0, a_valid = 0, c_ready = 0;
   logic [KW-1:0] k_len = '0;
   logic [S*DW-1:0] a_col = '0, b_row = '0;
   logic a_ready, c_valid, busy, done;
   logic [CW-1:0] c_data, exp_flat = '0, got;
`ifdef SYSTOLIC_PERF_CNT_EN
   logic [15:0] cycle_count;
`endif
   logic [DW-1:0] am [S][KM];
   logic [DW-1:0] bm [KM][S];
   logic [7:0] pat = 8'b11011001;
   int n_chk = 0, n_fail = 0, done_cnt = 0, busy_cyc = 0;

   systolic_stream_mm dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len), .signed_mode(signed_mode),
      .a_valid(a_valid), .a_ready(a_ready), .a_col(a_col), .b_row(b_row),
      .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data), .busy(busy), .done(done)
`ifdef SYSTOLIC_PERF_CNT_EN
      , .cycle_count(cycle_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model(input int kk, input bit s);
      for (int i = 0; i < S; i++)
         for (int j = 0; j < S; j++) begin
            int sum = 0;
            for (int k = 0; k < kk; k++)
               sum += (s ? int'($signed(am[i][k])) : int'(am[i][k])) *
                      (s ? int'($signed(bm[k][j])) : int'(bm[k][j]));
            exp_flat[(i*S+j)*AW +: AW] = AW'(sum);
         end
   endtask

   task automatic fill_rand();
      for (int i = 0; i < S; i++)
         for (int k = 0; k < KM; k++) begin
            am[i][k] = DW'($urandom);
            bm[k][i] = DW'($urandom);
         end
   endtask

   task automatic drive_beat(input int b);
      for (int i = 0; i < S; i++) begin
         a_col[i*DW +: DW] = am[i][b];
         b_row[i*DW +: DW] = bm[b][i];
      end
   endtask

   always @(negedge clk) if (!rst) begin
      if (c_valid) begin
         n_chk++;
         if (c_data !== exp_flat) begin
            n_fail++;
            $display("FAIL c_data: got %h expected %h", c_data, exp_flat);
         end
      end
      chk("done_vs_handshake", done, c_valid & c_ready);
      if (done) done_cnt++;
      if (busy) busy_cyc++;
   end

   // mode: 0 = one beat per cycle, 1 = fixed valid pattern, 2 = random valid
   task automatic job(input int k, input bit s, input int mode, input int hold, input bit poke);
      int kk, b, p, n;
      kk = k > KM ? KM : k;
      model(kk, s);
      busy_cyc = 0;
      done_cnt = 0;
      c_ready = hold == 0;
      start = 1;
      k_len = KW'(k);
      signed_mode = s;
      @(posedge clk); #1;
      start = 0;
      k_len = KW'($urandom);
      signed_mode = 1'($urandom);
      chk("busy_after_start", busy, 1);
      b = 0;
      p = 0;
      while (b < kk && p < 300) begin
         a_valid = mode == 0 ? 1'b1 : mode == 1 ? pat[p%8] : 1'($urandom_range(0, 1));
         if (a_valid) drive_beat(b);
         else begin
            a_col = $urandom;
            b_row = $urandom;
         end
         start = poke && b == 1;
         k_len = poke ? KW'(3) : k_len;
         @(negedge clk);
         chk("a_ready_load", a_ready, 1);
         @(posedge clk); #1;
         if (a_valid) b++;
         p++;
      end
      start = 0;
      if (p >= 300) chk("beat_budget", 64'(b), 64'(kk));
      a_valid = 1;
      a_col = $urandom;
      b_row = $urandom;
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         if (n == 0 && kk > 0) chk("a_ready_drop", a_ready, 0);
         if (c_valid) break;
         @(posedge clk); #1;
         start = poke && n == 2;
         n++;
      end
      start = 0;
      a_valid = 0;
      chk("latency", 64'(n), kk == 0 ? 64'd0 : 64'(2*S));
      got = c_data;
      if (hold == 0) chk("done_immediate", done, 1);
      else begin
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_valid", c_valid, 1);
            chk("hold_no_done", done, 0);
            chk("hold_stable", 64'(c_data == got), 1);
         end
         @(posedge clk); #1;
         c_ready = 1;
         @(negedge clk);
         chk("done_on_ready", done, 1);
      end
      @(posedge clk); #1;
      c_ready = 0;
      chk("idle_c_valid", c_valid, 0);
      chk("idle_busy", busy, 0);
`ifdef SYSTOLIC_PERF_CNT_EN
      chk("cycle_count", cycle_count, 64'(busy_cyc));
`endif
      @(negedge clk);
      chk("done_count", 64'(done_cnt), 1);
   endtask

   initial begin
      #1;
      chk("rst_a_ready", a_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_c_valid", c_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_c_data", 64'(c_data == '0), 1);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      // identity A times B yields B
      for (int i = 0; i < S; i++)
         for (int k = 0; k < KM; k++) begin
            am[i][k] = DW'(i == k);
            bm[k][i] = DW'(4*k + i);
         end
      job(4, 0, 0, 0, 0);
      for (int i = 0; i < S; i++)
         for (int j = 0; j < S; j++)
            chk("identity_lit", got[(i*S+j)*AW +: AW], 64'(4*i + j));
      for (int i = 0; i < S; i++)
         for (int k = 0; k < KM; k++) begin
            am[i][k] = 8'h80;
            bm[k][i] = 8'h80;
         end
      job(2, 1, 0, 0, 0);
      chk("signed_min_lit", got[0 +: AW], 32768);
      chk("signed_min_lit_last", got[(S*S-1)*AW +: AW], 32768);
      job(2, 0, 0, 0, 0);
      chk("unsigned_80_lit", got[5*AW +: AW], 32768);
      fill_rand();
      job(5, 0, 1, 0, 0);
      fill_rand();
      job(6, 1, 0, 20, 0);
      fill_rand();
      job(7, 0, 2, 0, 1);
      job(0, 0, 0, 0, 0);
      chk("k0_zero_lit", 64'(got == '0), 1);
      fill_rand();
      job(20, 1, 0, 0, 0);
      fill_rand();
      job(16, 0, 0, 3, 0);
      for (int r = 0; r < 6; r++) begin
         fill_rand();
         job($urandom_range(1, KM), 1'($urandom), 2, $urandom_range(0, 3), 1'($urandom));
      end
      // abort mid-load, then a clean job
      fill_rand();
      start = 1;
      k_len = 8;
      @(posedge clk); #1;
      start = 0;
      a_valid = 1;
      for (int b = 0; b < 3; b++) begin
         drive_beat(b);
         @(posedge clk); #1;
      end
      #2 rst = 1;
      #1;
      chk("abort_a_ready", a_ready, 0);
      chk("abort_busy", busy, 0);
      chk("abort_c_valid", c_valid, 0);
      chk("abort_done", done, 0);
      chk("abort_c_data", 64'(c_data == '0), 1);
      a_valid = 0;
      @(posedge clk); #1;
      rst = 0;
      fill_rand();
      job(9, 1, 2, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
